// File: rtl/memory_stage_pkg.sv
// Shared types and constants for the memory pipeline stage: FSM states,
// the EX/MEM entry layout and the default timeout counter width.
package mem_stage_pkg;

  localparam int DATA_W          = 8;
  localparam int REG_W           = 4;
  localparam int DEFAULT_TIMEOUT = 15;
  localparam int TIMEOUT_W       = $clog2(DEFAULT_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    ERROR
  } mem_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] wdata;
    logic [REG_W-1:0]  rd;
    logic              regWrite;
    logic              memRead;
    logic              memWrite;
    logic              valid;
    logic              killed;
  } ex_mem_t;

endpackage

// File: rtl/memory_stage_pipeline_reg.sv
// Generic pipeline register: async active-low clear, load enable, and a
// synchronous bubble that loads all zeros instead of d.
module pipeline_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             bubble,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= bubble ? '0 : d;
    end
  end

endmodule

// File: rtl/memory_stage.sv
// MEM pipeline stage: EX/MEM and MEM/WB registers, req/ack data-memory
// access FSM with wait states and timeout, and forwarding outputs.
module memory_stage
  import mem_stage_pkg::*;
#(
  parameter int WIDTH      = DATA_W,
  parameter int ADDR_WIDTH = 8,
  parameter int REG_BITS   = REG_W,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      aluOutputE,
  input  logic [WIDTH-1:0]      writeDataE,
  input  logic [REG_BITS-1:0]   rdE,
  input  logic                  regWriteE,
  input  logic                  memReadE,
  input  logic                  memWriteE,
  input  logic                  validE,
  input  logic                  bubbleE,
  input  logic                  killM,
  output logic [WIDTH-1:0]      forwardM,
  output logic [REG_BITS-1:0]   rdM,
  output logic                  regWriteM,
  output logic                  stallM,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  input  logic [WIDTH-1:0]      mem_rdata,
  input  logic                  mem_ack,
  output logic [WIDTH-1:0]      resultW,
  output logic [WIDTH-1:0]      forwardWB,
  output logic [REG_BITS-1:0]   rdW,
  output logic                  regWriteW,
  output logic                  bus_error
);

  localparam int CNT_RAW = $clog2(TIMEOUT + 1);
  localparam int CNT_W   = (CNT_RAW > TIMEOUT_W) ? CNT_RAW : TIMEOUT_W;
  localparam int WB_W    = WIDTH + REG_BITS + 1;

  mem_state_t       state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  ex_mem_t          exIn, exD, exMem;
  logic             exEn, exBubble, loadMem, isLoad;
  logic [WB_W-1:0]  wbD, wbQ;

  assign loadMem = validE & !bubbleE & (memReadE | memWriteE);
  assign stallM  = ((state == ACCESS) & !mem_ack) | (state == ERROR);

  // A stalled entry is rewritten onto itself only to latch the kill bit.
  always_comb begin
    exIn          = '0;
    exIn.alu      = aluOutputE;
    exIn.wdata    = writeDataE;
    exIn.rd       = rdE;
    exIn.regWrite = regWriteE;
    exIn.memRead  = memReadE;
    exIn.memWrite = memWriteE;
    exIn.valid    = validE;
    exD           = exIn;
    if (stallM) begin
      exD        = exMem;
      exD.killed = 1'b1;
    end
  end

  assign exEn     = !stallM | killM;
  assign exBubble = !stallM & bubbleE;

  pipeline_reg #(.WIDTH($bits(ex_mem_t))) u_ex_mem (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (exEn),
    .bubble (exBubble),
    .d      (exD),
    .q      (exMem)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    case (state)
      IDLE: begin
        if (loadMem) stateNext = ACCESS;
      end
      ACCESS: begin
        if (mem_ack) begin
          cntNext   = '0;
          stateNext = loadMem ? ACCESS : IDLE;
        end else begin
          cntNext = cnt + CNT_W'(1);
          if (cnt == CNT_W'(TIMEOUT - 1)) stateNext = ERROR;
        end
      end
      ERROR:   stateNext = ERROR;
      default: stateNext = IDLE;
    endcase
  end

  assign forwardM  = exMem.alu;
  assign rdM       = exMem.rd;
  assign regWriteM = exMem.valid & exMem.regWrite & !exMem.killed & !killM;
  assign mem_req   = (state == ACCESS);
  assign mem_we    = exMem.memWrite;
  assign mem_addr  = exMem.alu[ADDR_WIDTH-1:0];
  assign mem_wdata = exMem.wdata;
  assign bus_error = (state == ERROR);

  // Read+write together is a store, so only a pure read takes bus data.
  assign isLoad = exMem.memRead & !exMem.memWrite;
  assign wbD    = stallM ? {resultW, rdW, 1'b0}
                         : {(isLoad ? mem_rdata : exMem.alu), exMem.rd, regWriteM};

  pipeline_reg #(.WIDTH(WB_W)) u_mem_wb (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (1'b1),
    .bubble (1'b0),
    .d      (wbD),
    .q      (wbQ)
  );

  assign {resultW, rdW, regWriteW} = wbQ;
  assign forwardWB = resultW;

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage: ALU path, loads/stores with
// wait states, back-to-back access, kill, bubble, timeout and async reset.
module tb_memory_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] aluOutputE, writeDataE, mem_rdata;
  logic [3:0] rdE;
  logic       regWriteE, memReadE, memWriteE, validE, bubbleE, killM, mem_ack;
  logic [7:0] forwardM, mem_wdata, resultW, forwardWB, mem_addr;
  logic [3:0] rdM, rdW;
  logic       regWriteM, stallM, mem_req, mem_we, regWriteW, bus_error;

  int compared   = 0;
  int mismatched = 0;

  memory_stage dut (
    .clk(clk), .rst_n(rst_n), .aluOutputE(aluOutputE), .writeDataE(writeDataE),
    .rdE(rdE), .regWriteE(regWriteE), .memReadE(memReadE), .memWriteE(memWriteE),
    .validE(validE), .bubbleE(bubbleE), .killM(killM), .forwardM(forwardM),
    .rdM(rdM), .regWriteM(regWriteM), .stallM(stallM), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .resultW(resultW),
    .forwardWB(forwardWB), .rdW(rdW), .regWriteW(regWriteW), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] alu, input logic [7:0] wd,
                               input logic [3:0] rd, input logic rw, input logic mr,
                               input logic mw, input logic v);
    aluOutputE = alu; writeDataE = wd; rdE = rd;
    regWriteE = rw; memReadE = mr; memWriteE = mw; validE = v; bubbleE = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; killM = 1'b0; mem_ack = 1'b0; mem_rdata = 8'h00;
    applyStimulus(8'h00, 8'h00, 4'h0, 0, 0, 0, 0);
    #12;
    compared++; if (mem_req !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_req got %b expected 0", mem_req); end
    compared++; if (stallM !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_stall got %b expected 0", stallM); end
    compared++; if (bus_error !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_buserr got %b expected 0", bus_error); end
    compared++; if ({forwardM, resultW, regWriteW, regWriteM} !== 18'h0) begin mismatched++; $display("[TB] FAIL reset_regs got %h/%h/%b/%b expected zeros", forwardM, resultW, regWriteW, regWriteM); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_alu();
    int stalls = 0;
    applyStimulus(8'h3C, 8'h00, 4'd5, 1, 0, 0, 1);
    if (stallM) stalls++;
    tick();
    applyStimulus(8'h00, 8'h00, 4'h0, 0, 0, 0, 0);
    #1; if (stallM) stalls++;
    compared++; if (forwardM !== 8'h3C) begin mismatched++; $display("[TB] FAIL alu_forwardM got %h expected 3c", forwardM); end
    compared++; if ({rdM, regWriteM} !== {4'd5, 1'b1}) begin mismatched++; $display("[TB] FAIL alu_rdM got %h/%b expected 5/1", rdM, regWriteM); end
    tick();
    if (stallM) stalls++;
    compared++; if ({resultW, rdW, regWriteW} !== {8'h3C, 4'd5, 1'b1}) begin mismatched++; $display("[TB] FAIL alu_wb got %h/%h/%b expected 3c/5/1", resultW, rdW, regWriteW); end
    compared++; if (forwardWB !== 8'h3C) begin mismatched++; $display("[TB] FAIL alu_forwardWB got %h expected 3c", forwardWB); end
    tick();
    compared++; if (regWriteW !== 1'b0) begin mismatched++; $display("[TB] FAIL alu_wb_once got %b expected 0", regWriteW); end
    compared++; if (stalls !== 0) begin mismatched++; $display("[TB] FAIL alu_nostall got %0d expected 0", stalls); end
  endtask

  task automatic test_load_wait();
    int reqCnt = 0, stallCnt = 0, pulses = 0;
    logic addrOk = 1'b1, wbDuringStall = 1'b0;
    logic [7:0] wbVal = 8'h00;
    applyStimulus(8'h10, 8'h00, 4'd3, 1, 1, 0, 1);
    tick();
    applyStimulus(8'h00, 8'h00, 4'h0, 0, 0, 0, 0);
    for (int c = 0; c < 6; c++) begin
      mem_ack   = (c == 2);
      mem_rdata = (c == 2) ? 8'hA5 : 8'h00;
      #1;
      if (mem_req) begin reqCnt++; if (mem_addr !== 8'h10 || mem_we !== 1'b0) addrOk = 1'b0; end
      if (stallM) begin stallCnt++; if (regWriteW) wbDuringStall = 1'b1; end
      if (regWriteW) begin pulses++; wbVal = resultW; end
      tick();
    end
    mem_ack = 1'b0;
    compared++; if (reqCnt !== 3) begin mismatched++; $display("[TB] FAIL load_req_cycles got %0d expected 3", reqCnt); end
    compared++; if (stallCnt !== 2) begin mismatched++; $display("[TB] FAIL load_stall_cycles got %0d expected 2", stallCnt); end
    compared++; if (addrOk !== 1'b1) begin mismatched++; $display("[TB] FAIL load_addr_stable got %b expected 1", addrOk); end
    compared++; if (wbDuringStall !== 1'b0) begin mismatched++; $display("[TB] FAIL load_wb_in_stall got %b expected 0", wbDuringStall); end
    compared++; if (pulses !== 1) begin mismatched++; $display("[TB] FAIL load_wb_pulses got %0d expected 1", pulses); end
    compared++; if (wbVal !== 8'hA5) begin mismatched++; $display("[TB] FAIL load_result got %h expected a5", wbVal); end
  endtask

  task automatic test_store();
    applyStimulus(8'h22, 8'h7E, 4'd0, 0, 0, 1, 1);
    tick();
    applyStimulus(8'h00, 8'h00, 4'h0, 0, 0, 0, 0);
    mem_ack = 1'b1;
    #1;
    compared++; if ({mem_req, mem_we} !== 2'b11) begin mismatched++; $display("[TB] FAIL store_req_we got %b%b expected 11", mem_req, mem_we); end
    compared++; if ({mem_addr, mem_wdata} !== 16'h227E) begin mismatched++; $display("[TB] FAIL store_bus got %h/%h expected 22/7e", mem_addr, mem_wdata); end
    compared++; if (stallM !== 1'b0) begin mismatched++; $display("[TB] FAIL store_stall got %b expected 0", stallM); end
    tick();
    mem_ack = 1'b0;
    #1;
    compared++; if ({mem_req, regWriteW} !== 2'b00) begin mismatched++; $display("[TB] FAIL store_after got req=%b wb=%b expected 0/0", mem_req, regWriteW); end
  endtask

  task automatic test_back_to_back();
    applyStimulus(8'h40, 8'h00, 4'd1, 1, 1, 0, 1);
    tick();
    applyStimulus(8'h41, 8'h00, 4'd2, 1, 1, 0, 1);
    mem_ack = 1'b1; mem_rdata = 8'h11;
    #1;
    compared++; if ({mem_req, stallM, mem_addr} !== {2'b10, 8'h40}) begin mismatched++; $display("[TB] FAIL b2b_first got req=%b stall=%b addr=%h expected 1/0/40", mem_req, stallM, mem_addr); end
    tick();
    applyStimulus(8'h00, 8'h00, 4'h0, 0, 0, 0, 0);
    mem_rdata = 8'h22;
    #1;
    compared++; if ({mem_req, stallM, mem_addr} !== {2'b10, 8'h41}) begin mismatched++; $display("[TB] FAIL b2b_second got req=%b stall=%b addr=%h expected 1/0/41", mem_req, stallM, mem_addr); end
    compared++; if ({resultW, rdW, regWriteW} !== {8'h11, 4'd1, 1'b1}) begin mismatched++; $display("[TB] FAIL b2b_wb1 got %h/%h/%b expected 11/1/1", resultW, rdW, regWriteW); end
    tick();
    mem_ack = 1'b0;
    #1;
    compared++; if ({resultW, rdW, regWriteW} !== {8'h22, 4'd2, 1'b1}) begin mismatched++; $display("[TB] FAIL b2b_wb2 got %h/%h/%b expected 22/2/1", resultW, rdW, regWriteW); end
    compared++; if (mem_req !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_idle got %b expected 0", mem_req); end
  endtask

  task automatic test_kill();
    int reqCnt = 0;
    logic wbSeen = 1'b0;
    applyStimulus(8'h55, 8'h00, 4'd6, 1, 1, 0, 1);
    tick();
    applyStimulus(8'h00, 8'h00, 4'h0, 0, 0, 0, 0);
    for (int c = 0; c < 5; c++) begin
      killM     = (c == 0);
      mem_ack   = (c == 2);
      mem_rdata = (c == 2) ? 8'h99 : 8'h00;
      #1;
      if (mem_req) reqCnt++;
      if (regWriteW || (mem_req && regWriteM)) wbSeen = 1'b1;
      tick();
    end
    killM = 1'b0; mem_ack = 1'b0;
    compared++; if (reqCnt !== 3) begin mismatched++; $display("[TB] FAIL kill_req_held got %0d expected 3", reqCnt); end
    compared++; if (wbSeen !== 1'b0) begin mismatched++; $display("[TB] FAIL kill_no_write got %b expected 0", wbSeen); end
  endtask

  task automatic test_bubble();
    applyStimulus(8'h66, 8'h00, 4'd7, 1, 1, 0, 1);
    bubbleE = 1'b1;
    tick();
    bubbleE = 1'b0;
    applyStimulus(8'h00, 8'h00, 4'h0, 0, 0, 0, 0);
    #1;
    compared++; if ({mem_req, regWriteM, forwardM} !== 10'h0) begin mismatched++; $display("[TB] FAIL bubble got req=%b rw=%b fwd=%h expected 0/0/00", mem_req, regWriteM, forwardM); end
  endtask

  task automatic test_timeout();
    int reqCnt = 0;
    applyStimulus(8'h77, 8'h00, 4'd8, 1, 1, 0, 1);
    tick();
    applyStimulus(8'h00, 8'h00, 4'h0, 0, 0, 0, 0);
    for (int c = 0; c < 25 && !bus_error; c++) begin
      if (mem_req) reqCnt++;
      tick();
    end
    compared++; if (reqCnt !== 15) begin mismatched++; $display("[TB] FAIL timeout_req_cycles got %0d expected 15", reqCnt); end
    compared++; if ({bus_error, mem_req, stallM} !== 3'b101) begin mismatched++; $display("[TB] FAIL timeout_error got err=%b req=%b stall=%b expected 1/0/1", bus_error, mem_req, stallM); end
    mem_ack = 1'b1;
    tick(); tick();
    mem_ack = 1'b0;
    compared++; if ({bus_error, mem_req, stallM} !== 3'b101) begin mismatched++; $display("[TB] FAIL error_sticky got err=%b req=%b stall=%b expected 1/0/1", bus_error, mem_req, stallM); end
    #2 rst_n = 1'b0;
    #1;
    compared++; if ({bus_error, stallM, mem_req} !== 3'b000) begin mismatched++; $display("[TB] FAIL async_reset_ctl got err=%b stall=%b req=%b expected 0/0/0", bus_error, stallM, mem_req); end
    compared++; if ({forwardM, resultW} !== 16'h0) begin mismatched++; $display("[TB] FAIL async_reset_data got %h/%h expected 00/00", forwardM, resultW); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    $display("[TB] memory_stage bench start");
    test_reset();
    test_alu();
    test_load_wait();
    test_store();
    test_back_to_back();
    test_kill();
    test_bubble();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Holds the EX/MEM register and the MEM/WB register.
- Performs load/store accesses on a req/ack data-memory bus with variable wait states. Stalls upstream while an access is pending.
- Supplies the forwardM and forwardWB values that feed back to the execute stage's forwarding muxes.

Parameters:
WIDTH, 8, datapath/data-memory word width
ADDR_WIDTH, 8, data-memory address width; mem_addr = aluOutputE low ADDR_WIDTH bits
REG_BITS, 4, destination register index width
TIMEOUT, 15, max cycles in ACCESS without ack before bus error (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
aluOutputE  in  WIDTH  ALU result from execute
writeDataE  in  WIDTH  store data (forwarded data2) from execute
rdE  in  REG_BITS  destination register
regWriteE, memReadE, memWriteE, validE  in  1 each  control from execute
bubbleE  in  1  capture a bubble into EX/MEM instead of EX inputs
killM  in  1  squash the instruction currently in EX/MEM
forwardM  out  WIDTH  EX/MEM ALU result
rdM  out  REG_BITS  EX/MEM destination
regWriteM  out  1  validM & regWriteM & !killed
stallM  out  1  freeze upstream stages
mem_req, mem_we  out  1 each  bus request / write enable
mem_addr  out  ADDR_WIDTH  bus address
mem_wdata  out  WIDTH  bus write data
mem_rdata  in  WIDTH  bus read data, valid with mem_ack
mem_ack  in  1  access complete, single-cycle pulse
resultW, forwardWB  out  WIDTH  MEM/WB result (identical)
rdW  out  REG_BITS  MEM/WB destination
regWriteW  out  1  register-file write enable
bus_error  out  1  sticky timeout flag

Behaviour:
Reset (rst_n=0, async):
- All outputs and registers 0. State IDLE. Timeout counter 0.
- Reset mid-access drops mem_req immediately.

State machine (mem_state_t):
- IDLE to ACCESS: on a rising edge where EX/MEM loads validE & !bubbleE & (memReadE|memWriteE).
- ACCESS with mem_ack=1: EX/MEM loads the next instruction. Next state is ACCESS if that instruction is a memory op, else IDLE. Counter cleared.
- ACCESS with mem_ack=0: counter increments. When it reaches TIMEOUT, go to ERROR.
- ERROR is terminal until reset.

Bus outputs:
- mem_req = (state==ACCESS).
- mem_we = memWrite of EX/MEM.
- mem_addr and mem_wdata come from EX/MEM. They stay stable while mem_req=1.
- Once raised, mem_req stays high until ack or timeout.
- memRead and memWrite both set: treated as a write.

Stall:
- stallM = (ACCESS & !mem_ack) | ERROR.
- bus_error = (state==ERROR).

EX/MEM register:
- Enabled when !stallM.
- On load, validM <= validE & !bubbleE.

Kill:
- killM sets the killed bit of the current entry.
- The entry still completes any outstanding access: no early req drop. Handshake integrity beats flush.
- A killed entry never asserts regWriteM or regWriteW.

MEM/WB register:
- When !stallM: resultW <= memReadM ? mem_rdata : aluOutputM; rdW <= rdM; regWriteW <= regWriteM.
- When stallM: regWriteW <= 0 (bubble to WB, prevents a double write). resultW and rdW hold.

Latency:
- Non-memory op: 1 cycle EX to MEM, 1 cycle MEM to WB.
- Memory op: 1 + wait cycles; a zero-wait ack in the first ACCESS cycle costs no stall.
- Back-to-back memory ops with immediate ack sustain 1 per cycle.

Decomposition:
- Package mem_stage_pkg holds:
  - mem_state_t enum {IDLE, ACCESS, ERROR}
  - constant TIMEOUT_W = $clog2(TIMEOUT+1)
  - ex_mem_t packed struct {alu, wdata, rd, regWrite, memRead, memWrite, valid, killed}
- Sub-module pipeline_reg #(WIDTH): async active-low clear, enable, synchronous bubble load. Instantiated for EX/MEM and MEM/WB.

Test Plan:
1. ALU op: aluOutputE=0x3C, rdE=5, regWriteE=1, no mem -> forwardM=0x3C after 1 edge; resultW=0x3C, rdW=5, regWriteW=1 after 2 edges; stallM never 1.
2. Load, addr 0x10, ack 3 cycles after req with rdata=0xA5 -> mem_req high 3 cycles, mem_addr=0x10 stable; stallM=1 exactly 2 cycles; regWriteW=0 during stall, then resultW=0xA5, regWriteW=1 once.
3. Store, writeDataE=0x7E, addr 0x22, zero-wait ack -> one req cycle with mem_we=1, mem_wdata=0x7E; stallM=0; regWriteW=0.
4. Back-to-back load, load, each zero-wait ack -> mem_req high 2 consecutive cycles, state stays ACCESS, no stall, two regWriteW pulses.
5. Load then killM in the first ACCESS cycle, ack 2 cycles later -> mem_req held to ack; regWriteW stays 0 for that load.
6. No ack for TIMEOUT=15 cycles -> bus_error=1, mem_req=0, stallM=1 permanently; rst_n low mid-ERROR clears everything asynchronously.
